// File: rtl/serial_sum_receiver.sv
// serial_sum_receiver: deserializes the LSB-first bit-serial sum stream and
// its carry-out into a parallel word, then holds it on a valid/ready output.
// Optional feature macro: SERIAL_RX_PARITY_EN adds one trailing even-parity
// bit per frame (PAR state) and reports a mismatch on out_perr; without it
// the frame is WIDTH bits long and out_perr stays 0.
module serial_sum_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_start,
    input  logic             ser_bit,
    input  logic             ser_cout,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout,
    output logic             out_perr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t             state;
    logic [CW-1:0]      count;
    // Holds the bits received so far; the newest bit enters at the top so
    // that after a full frame bit 0 has walked down to the LSB.
    logic [WIDTH-2:0]   shift_reg;
    logic [WIDTH-1:0]   next_word;
    logic               commit_now;
    logic [WIDTH-1:0]   commit_data;
    logic               commit_cout;
    logic               commit_perr;

`ifdef SERIAL_RX_PARITY_EN
    logic [WIDTH-1:0]   frame_word;
    logic               hold_cout;
`endif

    assign next_word = {ser_bit, shift_reg};
    assign busy      = (state != IDLE);

    // Decide whether this cycle completes a frame and what word it delivers.
    always_comb begin
        commit_now  = 1'b0;
        commit_data = next_word;
        commit_cout = ser_cout;
        commit_perr = 1'b0;
        case (state)
`ifdef SERIAL_RX_PARITY_EN
            PAR: begin
                commit_now  = !ser_start;
                commit_data = frame_word;
                commit_cout = hold_cout;
                commit_perr = ser_bit ^ (^frame_word);
            end
`else
            SHIFT: begin
                commit_now = !ser_start && (count == LAST);
            end
`endif
            default: ;
        endcase
    end

    // Frame FSM plus the registered output word, handshake and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            shift_reg <= '0;
            out_data  <= '0;
            out_cout  <= 1'b0;
            out_perr  <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            frame_word <= '0;
            hold_cout  <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (commit_now) begin
                if (!out_valid || out_ready) begin
                    out_data  <= commit_data;
                    out_cout  <= commit_cout;
                    out_perr  <= commit_perr;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (ser_start) begin
                        shift_reg <= next_word[WIDTH-1:1];
                        count     <= CW'(1);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_start) begin
                        shift_reg <= next_word[WIDTH-1:1];
                        count     <= CW'(1);
                        state     <= SHIFT;
                    end else begin
                        shift_reg <= next_word[WIDTH-1:1];
                        if (count == LAST) begin
                            count <= '0;
`ifdef SERIAL_RX_PARITY_EN
                            frame_word <= next_word;
                            hold_cout  <= ser_cout;
                            state      <= PAR;
`else
                            state <= IDLE;
`endif
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PAR: begin
                    if (ser_start) begin
                        shift_reg <= next_word[WIDTH-1:1];
                        count     <= CW'(1);
                        state     <= SHIFT;
                    end else begin
                        count <= '0;
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sum_receiver.sv
// tb_serial_sum_receiver: directed frames for serial_sum_receiver with a
// scoreboard queue filled by the driver and drained by an output monitor.
module tb_serial_sum_receiver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ser_start = 1'b0;
    logic         ser_bit = 1'b0;
    logic         ser_cout = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_cout;
    logic         out_perr;
    logic         out_valid;
    logic         busy;
    logic         overrun;

    typedef struct packed {
        logic [W-1:0] data;
        logic         cout;
        logic         perr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_compared = 0;
    int   n_mismatched = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    serial_sum_receiver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_start (ser_start),
        .ser_bit   (ser_bit),
        .ser_cout  (ser_cout),
        .out_data  (out_data),
        .out_cout  (out_cout),
        .out_perr  (out_perr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic evenPar(input logic [W-1:0] d);
        return ^d;
    endfunction

    function automatic logic expPerr(input logic [W-1:0] d, input logic p);
`ifdef SERIAL_RX_PARITY_EN
        return p ^ (^d);
`else
        return 1'b0;
`endif
    endfunction

    // Holds the given inputs across exactly one rising edge.
    task automatic driveCycle(input logic s, input logic b, input logic c);
        ser_start = s;
        ser_bit   = b;
        ser_cout  = c;
        @(posedge clk);
        #1;
    endtask

    // Sends one full frame; returns just after the edge that completes it.
    task automatic applyStimulus(input logic [W-1:0] data, input logic cout,
                                 input logic par_bit, input bit expect_out);
        logic [W-1:0] d;
        d = data;
        if (expect_out) begin
            sb_q.push_back('{data: d, cout: cout, perr: expPerr(d, par_bit)});
        end
        for (int i = 0; i < W; i++) begin
            driveCycle(i == 0, d[i], (i == W - 1) ? cout : 1'b0);
        end
`ifdef SERIAL_RX_PARITY_EN
        driveCycle(1'b0, par_bit, 1'b0);
`endif
        ser_start = 1'b0;
        ser_bit   = par_bit;
        ser_cout  = 1'b0;
    endtask

    // Monitor: each negedge with valid&ready is one transfer at the next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_output: got data 0x%0h, expected no output", out_data);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("sb_data", 32'(out_data), 32'(mon_e.data));
                checkOutput("sb_cout", 32'(out_cout), 32'(mon_e.cout));
                checkOutput("sb_perr", 32'(out_perr), 32'(mon_e.perr));
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        #2;
        checkOutput("reset_valid", 32'(out_valid), 0);
        checkOutput("reset_data", 32'(out_data), 0);
        checkOutput("reset_cout", 32'(out_cout), 0);
        checkOutput("reset_perr", 32'(out_perr), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_overrun", 32'(overrun), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Partial 0x9D frame, then asynchronous reset mid-frame.
        driveCycle(1'b1, 1'b1, 1'b0);
        checkOutput("busy_in_frame", 32'(busy), 1);
        driveCycle(1'b0, 1'b0, 1'b0);
        driveCycle(1'b0, 1'b1, 1'b0);
        driveCycle(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 0);
        checkOutput("midreset_valid", 32'(out_valid), 0);
        checkOutput("midreset_data", 32'(out_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean 0x9D frame: valid right after the completing edge, for one cycle.
        applyStimulus(8'h9D, 1'b0, evenPar(8'h9D), 1'b1);
        checkOutput("basic_valid_latency", 32'(out_valid), 1);
        checkOutput("basic_data", 32'(out_data), 32'h9D);
        @(posedge clk);
        #1;
        checkOutput("basic_one_cycle_valid", 32'(out_valid), 0);
        checkOutput("basic_idle_busy", 32'(busy), 0);

        // Carry-only result, then a mixed pattern with carry.
        applyStimulus(8'h00, 1'b1, evenPar(8'h00), 1'b1);
        applyStimulus(8'hA5, 1'b1, evenPar(8'hA5), 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Frame A restarted at its bit 5 by a clean 0x5A frame.
        driveCycle(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) begin
            driveCycle(1'b0, 1'b1, 1'b0);
        end
        applyStimulus(8'h5A, 1'b0, evenPar(8'h5A), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("restart_overrun", 32'(overrun), 0);

`ifdef SERIAL_RX_PARITY_EN
        applyStimulus(8'h9D, 1'b0, 1'b1, 1'b1);
        checkOutput("par_good_perr", 32'(out_perr), 0);
        @(posedge clk);
        #1;
        applyStimulus(8'h9D, 1'b0, 1'b0, 1'b1);
        checkOutput("par_bad_perr", 32'(out_perr), 1);
        checkOutput("par_bad_data", 32'(out_data), 32'h9D);
        @(posedge clk);
        #1;
`endif

        // Back-to-back frames with downstream stalled: second one is dropped.
        out_ready = 1'b0;
        applyStimulus(8'h9D, 1'b0, evenPar(8'h9D), 1'b1);
        checkOutput("b2b_first_overrun", 32'(overrun), 0);
        applyStimulus(8'h3C, 1'b0, evenPar(8'h3C), 1'b0);
        checkOutput("b2b_overrun", 32'(overrun), 1);
        checkOutput("b2b_valid_held", 32'(out_valid), 1);
        checkOutput("b2b_data_held", 32'(out_data), 32'h9D);
        @(posedge clk);
        #1;
        checkOutput("b2b_data_stable", 32'(out_data), 32'h9D);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("b2b_valid_drop", 32'(out_valid), 0);
        checkOutput("b2b_overrun_sticky", 32'(overrun), 1);

        // Reset clears the sticky flag; receiver recovers afterwards.
        rst_n = 1'b0;
        #1;
        checkOutput("reset_clears_overrun", 32'(overrun), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(8'hC3, 1'b1, evenPar(8'hC3), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
